midi_tx: RTL and testbench
==========================

# midi_tx

MIDI message transmitter: the outbound counterpart of the `uart_rx` + `midi` receive path. It accepts one channel-voice event per request, builds the MIDI byte sequence, and serialises it on a 31250-baud-style UART line (8N1, LSB first). Running status is supported. It sits next to the synth top level and drives a MIDI OUT/THRU pin, or loops back into `uart_rx` for self-test.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 1600: CE-qualified clocks per serial bit (50 MHz / 31250). Minimum value is 2.
- `RUNNING_STATUS`, default 1: when 1, the status byte is omitted if it equals the last status byte sent.

Ports:
- `CLK`  in  1  System clock. Single clock domain.
- `RST`  in  1  Reset. Synchronous, active-high.
- `CE`  in  1  Clock enable. When low, all state holds, including the baud counter.
- `REQ`  in  1  Event request. Sampled only when `READY`=1 and `CE`=1.
- `TYPE`  in  2  Event type: 0 = note off, 1 = note on, 2 = program change, 3 = reserved.
- `CHANNEL`  in  4  MIDI channel, 0–15.
- `NOTE_NUM`  in  7  Note number, used by types 0 and 1.
- `NOTE_VEL`  in  7  Velocity, used by types 0 and 1.
- `PROGRAM`  in  7  Program number, used by type 2.
- `READY`  out  1  1 = idle and able to accept a request.
- `DO`  out  1  Serial data out. Idle level is 1.

## Operation

- Status byte by type:
  - Type 0: `8'h80 | CHANNEL`.
  - Type 1: `8'h90 | CHANNEL`.
  - Type 2: `8'hC0 | CHANNEL`.
- Message content:
  - Types 0 and 1: status, `{1'b0,NOTE_NUM}`, `{1'b0,NOTE_VEL}`.
  - Type 2: status, `{1'b0,PROGRAM}`.
- Acceptance: `REQ`=1 with `READY`=1 and `CE`=1. All inputs are latched on that edge. Later input changes do not affect the message in flight.
- Type 3 request: ignored. `READY` stays 1 and no bits are sent.
- `REQ` while `READY`=0 is ignored. No queueing.
- Running status register `last_status` (8 bits):
  - Valid flag is cleared by reset.
  - After each status byte is sent, `last_status` is set to that byte and the flag is set.
  - With `RUNNING_STATUS`=1, the flag set, and the new status equal to `last_status`, the status byte is skipped. Message length is then 2 bytes (note) or 1 byte (program change).
- Byte count n ∈ {1,2,3} is fixed at acceptance.
- FSM states: IDLE → START → DATA → STOP → (next byte ? START : IDLE).
  - IDLE: `DO`=1, `READY`=1.
  - START: `DO`=0.
  - DATA: `DO`=`shreg[0]`, shifting right once per bit. The bit index counts 0..7.
  - STOP: `DO`=1.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 on CE cycles.
  - On wrap, the FSM advances one bit.
  - The counter resets to 0 on every state entry from IDLE.
- Bytes are sent back to back: the next START follows the previous STOP immediately, with no extra idle bits.
- Reset values: `READY`=1, `DO`=1, FSM in IDLE, counters 0, running status flag cleared.
- Reset mid-frame: `DO` returns to 1 and `READY` to 1 on the reset edge. The message is abandoned and the running status flag is cleared, so the next message sends full status.

## Timing

- Acceptance at edge k: `READY`=0 and `DO`=0 (start bit) are visible from edge k+1.
- Each bit lasts exactly `CLKS_PER_BIT` CE-high cycles.
- One byte takes 10 bit times.
- `READY` returns to 1 at edge k+1+10·n·`CLKS_PER_BIT` (CE held high). A new `REQ` may be accepted on that same edge's following cycle, giving a gapless stream.
- CE low for m cycles stretches the message by exactly m cycles. `DO` holds its value during those cycles.
- `DO` is registered, with no combinational path from inputs.

## Test plan

Use `CLKS_PER_BIT`=4 and `RUNNING_STATUS`=1 unless noted. Decode `DO` with the existing `uart_rx` + `midi` chain plus a bit-level monitor.

1. Note on: after reset, REQ with TYPE=1, CH=0, NOTE=60, VEL=100 → bytes 0x90, 0x3C, 0x64. `READY` low for exactly 120 cycles. `midi` outputs NOTE_NUM=60 and NOTE_VEL=100.
2. Running status: immediately follow test 1 with TYPE=1, CH=0, NOTE=64, VEL=0 → bytes 0x40, 0x00 only, with `READY` low for 80 cycles. Then TYPE=0, CH=0 → full status 0x80 is sent.
3. Program change: TYPE=2, CH=5, PROG=7 → bytes 0xC5, 0x07 (80 cycles). Repeat the same request → 0x07 only (40 cycles). With `RUNNING_STATUS`=0 → 0xC5 is sent both times.
4. Handshake edges:
   - REQ held high during a message → exactly one extra message, accepted at the first `READY`=1 cycle.
   - TYPE=3 → no `DO` activity and `READY` stays 1.
   - Inputs changed mid-message → transmitted bytes unchanged.
5. CE gating: toggle CE at 50% during test 1 → same bytes, total duration 240 clocks, bit widths exactly 8 clocks.
6. Reset mid-frame: assert `RST` during the DATA bits of the second byte → `DO`=1 and `READY`=1 on the next edge. The next identical note-on sends full status 0x90.

Source files
------------

// File: rtl/midi_tx.sv
// midi_tx: builds MIDI channel-voice messages (note off, note on, program
// change) from one request and serialises them as 8N1 UART frames, LSB first,
// with optional running-status suppression of repeated status bytes.
module midi_tx #(
   parameter int CLKS_PER_BIT   = 1600,
   parameter int RUNNING_STATUS = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE,
   input  logic       REQ,
   input  logic [1:0] TYPE,
   input  logic [3:0] CHANNEL,
   input  logic [6:0] NOTE_NUM,
   input  logic [6:0] NOTE_VEL,
   input  logic [6:0] PROGRAM,
   output logic       READY,
   output logic       DO
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [1:0]    rem, rem_n;          // bytes still queued after the current one
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    q1, q1_n;            // next byte to send
   logic [7:0]    q2, q2_n;            // byte after that
   logic [7:0]    last_status, last_status_n;
   logic          ls_valid, ls_valid_n;
   logic          do_r, do_n;

   logic [7:0]    status;
   logic [7:0]    data1;
   logic [7:0]    data2;
   logic          skip;
   logic          tick;

   // Message bytes derived from the request fields; used only on acceptance.
   always_comb begin
      status = {4'hC, CHANNEL};
      if (TYPE == 2'd0) status = {4'h8, CHANNEL};
      if (TYPE == 2'd1) status = {4'h9, CHANNEL};
      data1 = (TYPE == 2'd2) ? {1'b0, PROGRAM} : {1'b0, NOTE_NUM};
      data2 = {1'b0, NOTE_VEL};
      skip  = (RUNNING_STATUS != 0) && ls_valid && (status == last_status);
      tick  = CE && (cnt == CNT_LAST);
   end

   // Next-state and datapath: latch the message on acceptance, then walk
   // start/data/stop bits, one bit per baud-counter wrap.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      bit_idx_n     = bit_idx;
      rem_n         = rem;
      shreg_n       = shreg;
      q1_n          = q1;
      q2_n          = q2;
      last_status_n = last_status;
      ls_valid_n    = ls_valid;
      do_n          = do_r;

      case (state)
         S_IDLE: begin
            if (CE && REQ && (TYPE != 2'd3)) begin
               state_n   = S_START;
               cnt_n     = '0;
               bit_idx_n = '0;
               if (skip) begin
                  shreg_n = data1;
                  q1_n    = data2;
                  rem_n   = (TYPE == 2'd2) ? 2'd0 : 2'd1;
               end else begin
                  shreg_n = status;
                  q1_n    = data1;
                  q2_n    = data2;
                  rem_n   = (TYPE == 2'd2) ? 2'd1 : 2'd2;
                  // Recorded at acceptance: an abandoned message always goes
                  // through reset, which clears the valid flag anyway.
                  last_status_n = status;
                  ls_valid_n    = 1'b1;
               end
            end
         end
         S_START: begin
            if (CE) cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
               state_n   = S_DATA;
               bit_idx_n = '0;
            end
         end
         S_DATA: begin
            if (CE) cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
               if (bit_idx == 3'd7) begin
                  state_n = S_STOP;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
                  shreg_n   = {1'b0, shreg[7:1]};
               end
            end
         end
         S_STOP: begin
            if (CE) cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
               if (rem != 2'd0) begin
                  state_n = S_START;
                  shreg_n = q1;
                  q1_n    = q2;
                  rem_n   = rem - 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase

      case (state_n)
         S_START: do_n = 1'b0;
         S_DATA:  do_n = shreg_n[0];
         default: do_n = 1'b1;
      endcase
   end

   // State register; control is reset, payload registers are don't-care in idle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         rem      <= '0;
         ls_valid <= 1'b0;
         do_r     <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_idx_n;
         rem      <= rem_n;
         ls_valid <= ls_valid_n;
         do_r     <= do_n;
      end
      shreg       <= shreg_n;
      q1          <= q1_n;
      q2          <= q2_n;
      last_status <= last_status_n;
   end

   assign READY = (state == S_IDLE);
   assign DO    = do_r;

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: two transmitters (running status on / off) share one stimulus
// stream; a CE-aware UART monitor per instance pops a byte scoreboard.
module tb_midi_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst, ce, req;
   logic [1:0] typ;
   logic [3:0] ch;
   logic [6:0] nn, nv, pg;
   logic       ready_a, do_a, ready_b, do_b;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int         ce_cnt = 0;
   int         gen    = 0;
   bit         va     = 1'b0;
   logic [7:0] lsa    = 8'h00;
   int         la, lb, na, nb;
   bit         bad;

   always #5 clk = ~clk;

   midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) dut_a (
      .CLK(clk), .RST(rst), .CE(ce), .REQ(req), .TYPE(typ), .CHANNEL(ch),
      .NOTE_NUM(nn), .NOTE_VEL(nv), .PROGRAM(pg), .READY(ready_a), .DO(do_a));

   midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(0)) dut_b (
      .CLK(clk), .RST(rst), .CE(ce), .REQ(req), .TYPE(typ), .CHANNEL(ch),
      .NOTE_NUM(nn), .NOTE_VEL(nv), .PROGRAM(pg), .READY(ready_b), .DO(do_b));

   always @(posedge clk) if (ce) ce_cnt <= ce_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decode 8N1 frames by counting CE-qualified edges from the start bit.
   task automatic monitor(input bit which);
      int         t0, g;
      logic [7:0] b;
      logic       s;
      forever begin
         @(negedge clk);
         s = which ? do_b : do_a;
         if (s === 1'b0) begin
            t0 = ce_cnt;
            g  = gen;
            b  = 8'h00;
            for (int j = 1; j <= 9 && gen == g; j++) begin
               while (ce_cnt < t0 + CPB * j + CPB / 2 && gen == g) @(negedge clk);
               if (gen == g) begin
                  s = which ? do_b : do_a;
                  if (j <= 8) begin
                     b[j-1] = s;
                  end else begin
                     check(which ? "stop_b" : "stop_a", {31'd0, s}, 32'd1);
                     if (which) begin
                        if (qb.size() == 0) check("unexpected_b", {24'd0, b}, 32'hFFFF_FFFF);
                        else check("byte_b", {24'd0, b}, {24'd0, qb.pop_front()});
                     end else begin
                        if (qa.size() == 0) check("unexpected_a", {24'd0, b}, 32'hFFFF_FFFF);
                        else check("byte_a", {24'd0, b}, {24'd0, qa.pop_front()});
                     end
                  end
               end
            end
         end
      end
   endtask

   initial monitor(1'b0);
   initial monitor(1'b1);

   // Reference model: push the bytes each instance must emit for one request.
   task automatic push_exp(input logic [1:0] t, input logic [3:0] c, input logic [6:0] n1,
                           input logic [6:0] n2, input logic [6:0] p,
                           output int ea, output int eb);
      logic [7:0] st, d1;
      st = (t == 2'd0) ? {4'h8, c} : (t == 2'd1) ? {4'h9, c} : {4'hC, c};
      d1 = (t == 2'd2) ? {1'b0, p} : {1'b0, n1};
      ea = 0;
      if (!(va && lsa == st)) begin
         qa.push_back(st);
         ea++;
      end
      va  = 1'b1;
      lsa = st;
      qa.push_back(d1);
      ea++;
      qb.push_back(st);
      qb.push_back(d1);
      eb = 2;
      if (t != 2'd2) begin
         qa.push_back({1'b0, n2});
         qb.push_back({1'b0, n2});
         ea++;
         eb++;
      end
   endtask

   task automatic start_msg(input logic [1:0] t, input logic [3:0] c, input logic [6:0] n1,
                            input logic [6:0] n2, input logic [6:0] p,
                            output int ea, output int eb);
      @(negedge clk);
      typ = t; ch = c; nn = n1; nv = n2; pg = p;
      req = 1'b1;
      ce  = 1'b1;
      push_exp(t, c, n1, n2, p, ea, eb);
   endtask

   // Count clocks with READY low on each instance until both are idle.
   task automatic wait_idle(input bit toggle, input bit scramble, output int ca, output int cb);
      bit done;
      ca = 0; cb = 0; done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (!ready_a) ca++;
         if (!ready_b) cb++;
         if (ready_a && ready_b) begin
            done = 1'b1;
         end else begin
            if (toggle) ce = ~ce;
            if (scramble) begin
               typ = 2'($urandom); ch = 4'($urandom);
               nn  = 7'($urandom); nv = 7'($urandom); pg = 7'($urandom);
            end
            @(negedge clk);
         end
      end
      if (!done) check("idle_timeout", 32'd0, 32'd1);
      ce = 1'b1;
   endtask

   task automatic msg(input logic [1:0] t, input logic [3:0] c, input logic [6:0] n1,
                      input logic [6:0] n2, input logic [6:0] p, input string tag,
                      input bit toggle, input bit scramble);
      int ea, eb, ca, cb;
      start_msg(t, c, n1, n2, p, ea, eb);
      @(negedge clk);
      req = 1'b0;
      wait_idle(toggle, scramble, ca, cb);
      check({tag, "_len_a"}, ca, ea * 10 * CPB * (toggle ? 2 : 1));
      check({tag, "_len_b"}, cb, eb * 10 * CPB * (toggle ? 2 : 1));
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; req = 1'b0;
      typ = 2'd0; ch = 4'd0; nn = 7'd0; nv = 7'd0; pg = 7'd0;
      repeat (3) @(negedge clk);
      check("rst_ready_a", {31'd0, ready_a}, 32'd1);
      check("rst_do_a",    {31'd0, do_a},    32'd1);
      check("rst_ready_b", {31'd0, ready_b}, 32'd1);
      check("rst_do_b",    {31'd0, do_b},    32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      msg(2'd1, 4'd0, 7'd60, 7'd100, 7'd0, "noteon", 1'b0, 1'b0);
      msg(2'd1, 4'd0, 7'd64, 7'd0,   7'd0, "runst",  1'b0, 1'b0);
      msg(2'd0, 4'd0, 7'd64, 7'd0,   7'd0, "noteoff", 1'b0, 1'b0);
      msg(2'd2, 4'd5, 7'd0,  7'd0,   7'd7, "prog1",  1'b0, 1'b0);
      msg(2'd2, 4'd5, 7'd0,  7'd0,   7'd7, "prog2",  1'b0, 1'b0);

      // REQ held through a whole message: exactly one re-acceptance.
      start_msg(2'd1, 4'd3, 7'd50, 7'd70, 7'd0, na, nb);
      @(negedge clk);
      wait_idle(1'b0, 1'b0, la, lb);
      check("hold1_len_a", la, na * 10 * CPB);
      check("hold1_len_b", lb, nb * 10 * CPB);
      push_exp(2'd1, 4'd3, 7'd50, 7'd70, 7'd0, na, nb);
      @(negedge clk);
      check("hold_acc_a", {31'd0, ready_a}, 32'd0);
      check("hold_acc_b", {31'd0, ready_b}, 32'd0);
      req = 1'b0;
      wait_idle(1'b0, 1'b0, la, lb);
      check("hold2_len_a", la, na * 10 * CPB);
      check("hold2_len_b", lb, nb * 10 * CPB);

      // Reserved type is ignored.
      @(negedge clk);
      typ = 2'd3; req = 1'b1; bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (!ready_a || !ready_b || !do_a || !do_b) bad = 1'b1;
      end
      req = 1'b0;
      check("type3_idle", {31'd0, bad}, 32'd0);

      msg(2'd1, 4'd7, 7'd11, 7'd22, 7'd0, "chg", 1'b0, 1'b1);
      msg(2'd1, 4'd0, 7'd60, 7'd100, 7'd0, "cegate", 1'b1, 1'b0);
      msg(2'd2, 4'd9, 7'd0, 7'd0, 7'd3, "prog9", 1'b0, 1'b0);

      // Reset during the data bits of the second byte.
      start_msg(2'd1, 4'd0, 7'd60, 7'd100, 7'd0, na, nb);
      @(negedge clk);
      req = 1'b0;
      repeat (51) @(negedge clk);
      rst = 1'b1;
      qa.delete();
      qb.delete();
      gen++;
      va = 1'b0;
      @(negedge clk);
      check("mrst_ready_a", {31'd0, ready_a}, 32'd1);
      check("mrst_do_a",    {31'd0, do_a},    32'd1);
      check("mrst_ready_b", {31'd0, ready_b}, 32'd1);
      check("mrst_do_b",    {31'd0, do_b},    32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      msg(2'd1, 4'd0, 7'd60, 7'd100, 7'd0, "postrst", 1'b0, 1'b0);

      repeat (20) @(negedge clk);
      check("qa_empty", qa.size(), 32'd0);
      check("qb_empty", qb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
